// File: rtl/led_fader.sv
// -----------------------------------------------------------------------------
// led_fader
// Sits after the LED scroller and drives the physical LEDs through per-LED PWM.
// A lit LED is held at full brightness. Once its input goes dark it fades out
// linearly, which gives the scrolling pattern a comet tail. With i_en low the
// raw pattern is passed through with a one-cycle register delay.
//
// Parameters
//   N_LED      number of LEDs
//   PWM_BITS   PWM counter / brightness width (period 2^PWM_BITS cycles)
//   DECAY_DIV  clock cycles per fade step (minimum 1)
//
// Ports
//   i_clk        system clock
//   i_reset      asynchronous, active-high reset
//   i_en         1 = fade/PWM mode, 0 = bypass (o_led_out follows i_led_in)
//   i_decay_sel  fade step per decay tick: 0->1, 1->2, 2->4, 3->8
//   i_led_in     raw LED pattern from the scroller
//   o_led_out    registered drive to the physical LEDs
// -----------------------------------------------------------------------------
module led_fader #(
    parameter int          N_LED     = 16,
    parameter int          PWM_BITS  = 8,
    parameter logic [26:0] DECAY_DIV = 27'd100000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [1:0]       i_decay_sel,
    input  logic [N_LED-1:0] i_led_in,
    output logic [N_LED-1:0] o_led_out
);

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] PWM_ONE  = 1;
    localparam logic [26:0]         DIV_LAST = DECAY_DIV - 27'd1;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [26:0]         r_decay_cnt;
    logic [PWM_BITS-1:0] r_bright [N_LED];

    logic                w_tick;
    // Step is kept 4 bits wider than the brightness so an 8-step still
    // compares correctly against brightness when PWM_BITS is small.
    logic [PWM_BITS+3:0] w_step;
    logic [PWM_BITS-1:0] w_bright_next [N_LED];
    logic [N_LED-1:0]    w_led_next;

    // With DECAY_DIV == 1 the counter sits at 0 and the tick is high every cycle.
    assign w_tick = (r_decay_cnt == DIV_LAST);
    assign w_step = {{PWM_BITS{1'b0}}, 4'b0001} << i_decay_sel;

    generate
        for (genvar gi = 0; gi < N_LED; gi++) begin : g_led
            logic [PWM_BITS+3:0] w_bright_ext;
            logic [PWM_BITS+3:0] w_bright_dec;
            logic [PWM_BITS-1:0] w_bright_fade;

            assign w_bright_ext  = {4'b0000, r_bright[gi]};
            assign w_bright_dec  = w_bright_ext - w_step;
            // Saturate at zero instead of wrapping when the step overshoots.
            assign w_bright_fade = (w_bright_ext <= w_step) ? '0
                                                            : w_bright_dec[PWM_BITS-1:0];

            // A lit input wins over a decay tick in the same cycle.
            assign w_bright_next[gi] = i_led_in[gi] ? MAX
                                     : (w_tick ? w_bright_fade : r_bright[gi]);

            // MAX is forced continuously on; otherwise high while pwm < bright,
            // so brightness 0 is continuously off.
            assign w_led_next[gi] = i_en ? ((r_bright[gi] == MAX) | (r_pwm_cnt < r_bright[gi]))
                                         : i_led_in[gi];
        end
    endgenerate

    // Counters and brightness keep running in bypass so switching back to
    // fade mode resumes with the accumulated brightness.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pwm_cnt   <= '0;
            r_decay_cnt <= '0;
            for (int i = 0; i < N_LED; i++) begin
                r_bright[i] <= '0;
            end
            o_led_out   <= '0;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + PWM_ONE;
            r_decay_cnt <= w_tick ? 27'd0 : (r_decay_cnt + 27'd1);
            for (int i = 0; i < N_LED; i++) begin
                r_bright[i] <= w_bright_next[i];
            end
            o_led_out   <= w_led_next;
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// -----------------------------------------------------------------------------
// tb_led_fader
// Directed, self-checking bench for led_fader with N_LED=4, PWM_BITS=4
// (MAX=15), DECAY_DIV=4. Every scenario starts from a fresh reset so decay
// ticks land on edges 4, 8, 12, ... after release and pwm_cnt after edge e
// equals e mod 16. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_led_fader;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] decay_sel;
    logic [3:0] led_in;
    logic [3:0] led_out;

    int n_pass;
    int n_checks;
    int cyc;

    led_fader #(
        .N_LED     (4),
        .PWM_BITS  (4),
        .DECAY_DIV (27'd4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_en        (en),
        .i_decay_sel (decay_sel),
        .i_led_in    (led_in),
        .o_led_out   (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Reset, then release with the given inputs so they are sampled at edge 1.
    task automatic do_reset(input logic [3:0] first_in, input logic first_en,
                            input logic [1:0] sel);
        @(negedge clk);
        reset = 1'b1;
        led_in = 4'h0;
        @(negedge clk);
        @(negedge clk);
        led_in    = first_in;
        en        = first_en;
        decay_sel = sel;
        reset     = 1'b0;
        cyc       = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b1; decay_sel = 2'd0; led_in = 4'hF;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (led_out !== 4'h0) $display("FAIL reset_hold led_out=%h expected=0", led_out);
        else n_pass++;
        n_checks++;
        if (dut.r_bright[0] !== 4'd0) $display("FAIL reset_hold_bright bright0=%0d expected=0", dut.r_bright[0]);
        else n_pass++;
        reset = 1'b0;
        cyc = 0;
        step();
        n_checks++;
        if (dut.r_bright[3] !== 4'd15) $display("FAIL reset_edge1_bright bright3=%0d expected=15", dut.r_bright[3]);
        else n_pass++;
        n_checks++;
        if (led_out !== 4'h0) $display("FAIL reset_edge1_led led_out=%h expected=0", led_out);
        else n_pass++;
        step();
        n_checks++;
        if (led_out !== 4'hF) $display("FAIL reset_edge2_led led_out=%h expected=f", led_out);
        else n_pass++;
        $display("test_reset done, edge=%0d led_out=%h", cyc, led_out);
    endtask

    task automatic test_fade_step1();
        int edges  [12] = '{11, 12, 13, 15, 16, 17, 39, 41, 64, 65, 68, 80};
        int brt    [12] = '{15, 14, 14, 14, 13, 13,  8,  7,  1,  1,  0,  0};
        int led    [12] = '{ 1,  1,  1,  0,  0,  1,  1,  0,  0,  1,  0,  0};
        int highs;
        do_reset(4'h1, 1'b1, 2'd0);
        for (int k = 0; k < 12; k++) begin
            while (cyc < edges[k]) begin
                step();
                if (cyc == 10) led_in = 4'h0;
            end
            n_checks++;
            if (dut.r_bright[0] !== brt[k][3:0])
                $display("FAIL fade1_bright edge=%0d bright0=%0d expected=%0d", cyc, dut.r_bright[0], brt[k]);
            else n_pass++;
            n_checks++;
            if (led_out[0] !== led[k][0])
                $display("FAIL fade1_led edge=%0d led0=%b expected=%0d", cyc, led_out[0], led[k]);
            else n_pass++;
            $display("fade1 edge=%0d bright0=%0d led0=%b", cyc, dut.r_bright[0], led_out[0]);
        end
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led_out[0]) highs++;
        end
        n_checks++;
        if (highs !== 0) $display("FAIL fade1_duty_zero highs=%0d expected=0", highs);
        else n_pass++;
    endtask

    task automatic test_step8();
        int edges [4] = '{3, 4, 8, 12};
        int brt   [4] = '{15, 7, 0, 0};
        do_reset(4'h1, 1'b1, 2'd3);
        step();
        led_in = 4'h0;      // one-cycle pulse
        for (int k = 0; k < 4; k++) begin
            run_to(edges[k]);
            n_checks++;
            if (dut.r_bright[0] !== brt[k][3:0])
                $display("FAIL step8_bright edge=%0d bright0=%0d expected=%0d", cyc, dut.r_bright[0], brt[k]);
            else n_pass++;
            $display("step8 edge=%0d bright0=%0d", cyc, dut.r_bright[0]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(4'h2, 1'b1, 2'd0);
        step();
        led_in = 4'h0;
        run_to(39);
        n_checks++;
        if (dut.r_bright[1] !== 4'd6) $display("FAIL simul_pre bright1=%0d expected=6", dut.r_bright[1]);
        else n_pass++;
        led_in = 4'h2;      // sampled at edge 40, which is a decay tick
        step();
        led_in = 4'h0;
        n_checks++;
        if (dut.r_bright[1] !== 4'd15) $display("FAIL simul_tick bright1=%0d expected=15", dut.r_bright[1]);
        else n_pass++;
        run_to(44);
        n_checks++;
        if (dut.r_bright[1] !== 4'd14) $display("FAIL simul_after bright1=%0d expected=14", dut.r_bright[1]);
        else n_pass++;
        $display("simultaneous edge=%0d bright1=%0d", cyc, dut.r_bright[1]);
    endtask

    task automatic test_bypass();
        logic [3:0] exp_out [5] = '{4'h1, 4'h2, 4'h4, 4'h7, 4'hF};
        logic [3:0] next_in [5] = '{4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
        do_reset(4'h1, 1'b0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (led_out !== exp_out[k])
                $display("FAIL bypass edge=%0d led_out=%h expected=%h", cyc, led_out, exp_out[k]);
            else n_pass++;
            $display("bypass edge=%0d en=%b led_out=%h", cyc, en, led_out);
            led_in = next_in[k];
            if (k == 2) en = 1'b1;   // fade mode from edge 4 onward
        end
    endtask

    task automatic test_async_reset();
        do_reset(4'h4, 1'b1, 2'd0);
        step();
        led_in = 4'h0;
        run_to(24);
        n_checks++;
        if (dut.r_bright[2] !== 4'd9) $display("FAIL async_pre bright2=%0d expected=9", dut.r_bright[2]);
        else n_pass++;
        n_checks++;
        if (led_out !== 4'h4) $display("FAIL async_pre_led led_out=%h expected=4", led_out);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (led_out !== 4'h0) $display("FAIL async_led led_out=%h expected=0", led_out);
        else n_pass++;
        n_checks++;
        if (dut.r_bright[2] !== 4'd0) $display("FAIL async_bright bright2=%0d expected=0", dut.r_bright[2]);
        else n_pass++;
        $display("async_reset led_out=%h bright2=%0d", led_out, dut.r_bright[2]);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_checks = 0; cyc = 0;
        reset = 1'b1; en = 1'b1; decay_sel = 2'd0; led_in = 4'h0;
        test_reset();
        test_fade_step1();
        test_step8();
        test_simultaneous();
        test_bypass();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_fader.md
# led_fader

Downstream stage of the LED scroller. Consumes the scroller's raw LED vector and drives the physical LEDs through per-LED PWM. A lit LED shows full brightness; once it goes dark it fades out linearly instead of snapping off, giving the scrolling pattern a comet tail. A bypass input lets the board show the raw pattern unchanged.

## Interface

- N_LED, 16, number of LEDs (width of led_in/led_out)
- PWM_BITS, 8, PWM counter and brightness width; period 2^PWM_BITS cycles; MAX = 2^PWM_BITS-1
- DECAY_DIV, 27'd100000, clk cycles per fade step; minimum 1
- clk  input  1  system clock, single clock domain
- reset  input  1  asynchronous, active-high reset
- en  input  1  1 = fade/PWM mode, 0 = bypass (led_out follows led_in)
- decay_sel  input  2  fade step size per decay tick: 0→1, 1→2, 2→4, 3→8
- led_in  input  N_LED  raw pattern from scroller, synchronous to clk
- led_out  output  N_LED  registered drive to physical LEDs

## Operation

- State: pwm_cnt (PWM_BITS, free-running, wraps MAX→0); decay_cnt (counts 0..DECAY_DIV-1, wraps); bright[i] (PWM_BITS each); led_out register.
- Decay tick: combinational, high in the cycle where decay_cnt == DECAY_DIV-1. With DECAY_DIV=1 the tick is high every cycle.
- Brightness update, each rising clk, per LED i, in priority order:
  - led_in[i]==1: bright[i] <= MAX.
  - Else if tick: bright[i] <= bright[i] - step, saturating at 0. Step is 1 << decay_sel. No underflow wrap.
  - Else: hold.
- led_in high beats a simultaneous decay tick.
- Output update, each rising clk:
  - en==1: led_out[i] <= (bright[i]==MAX) | (pwm_cnt < bright[i]). MAX is continuous on; 0 is continuous off.
  - en==0: led_out[i] <= led_in[i].
- Brightness, pwm_cnt and decay_cnt keep running in bypass mode. Toggling en takes effect on the next edge with no resync.
- decay_sel is sampled every tick. A change mid-fade applies from the next tick.
- No handshake. led_in may change every cycle. A 1-cycle led_in pulse still sets MAX.

## Timing

- Reset value: led_out=0, bright[*]=0, pwm_cnt=0, decay_cnt=0.
- Reset asserted mid-fade clears all state immediately (async).
- First edge after reset release: pwm_cnt=1, decay_cnt=1.
- Fade mode latency: led_in[i] rising sampled at edge k → bright[i]=MAX after edge k → led_out[i]=1 after edge k+1. The same 2-register path applies to fall/fade start.
- Bypass latency: 1 cycle (led_out after edge k equals led_in sampled at edge k).
- Fade duration from MAX to 0: ceil(MAX/step) ticks, i.e. 255 ticks at step 1 and 32 ticks at step 8 (the last one saturates 7→0).
- The first decrement happens on the first tick after led_in falls. Partial tick periods are not reset by led_in edges.
- PWM duty for brightness b (0<b<MAX): b high cycles per 2^PWM_BITS-cycle period, from pwm_cnt=0 through b-1.

## Test plan

Bench parameters: N_LED=4, PWM_BITS=4 (MAX=15, period 16), DECAY_DIV=4.

- Reset: hold reset with led_in=4'hF, release → led_out=0 while asserted; the first edge with reset low sets bright=15; led_out=4'hF one edge later; all outputs 0 whenever reset is high.
- Fade, step 1: led_in[0] 1 for 10 cycles then 0, decay_sel=0 → bright[0] steps 15,14,…,0, one step per 4 cycles; reaches 0 after 15 ticks (60 cycles) and stays 0; led_out[0] duty per 16-cycle period equals bright.
- Step 8 saturation: decay_sel=3, fade from 15 → values 15,7,0,0; no wrap to 15.
- Simultaneous: led_in[1] re-asserted on a tick cycle while bright[1]=6 → bright[1]=15, not 5.
- Bypass: en=0, led_in walks 1,2,4,8 one per cycle → led_out echoes with 1-cycle lag. Switch en=1 mid-walk → fade outputs resume next edge using brightness accumulated during bypass.
- Async reset mid-fade: assert reset between clk edges while bright[2]=9 → led_out and all bright clear immediately without a clk edge.
